// File: rtl/up_tpl_profile_seq.sv
// up_tpl_profile_seq: sequences a JESD204 TPL profile change (reset, switch, settle, release, sync)
//   up_clk/up_rstn              clock, async active-low reset
//   up_req_i/up_req_profile_i   profile-change request (sampled in IDLE only) and index
//   up_abort_i                  abort a running sequence
//   up_link_ready_i             deframer link up
//   up_sync_status_i            TPL sync status
//   up_profile_sel_o            active profile
//   up_core_rst_o               datapath reset request, active-high
//   up_ack_o/up_done_o          one-cycle pulses: request accepted/rejected, sequence completed
//   up_busy_o/up_error_o        busy outside IDLE; sticky error
//   up_state_o                  FSM state for debug readback
module up_tpl_profile_seq #(
  parameter int NUM_PROFILES  = 1,
  parameter int RST_CYCLES    = 16,
  parameter int SETTLE_CYCLES = 64,
  parameter int SYNC_TIMEOUT  = 65535,
  localparam int PW   = $clog2(NUM_PROFILES) + 1,
  localparam int MAXC = (RST_CYCLES > SETTLE_CYCLES ? RST_CYCLES : SETTLE_CYCLES) > SYNC_TIMEOUT ?
                        (RST_CYCLES > SETTLE_CYCLES ? RST_CYCLES : SETTLE_CYCLES) : SYNC_TIMEOUT,
  localparam int CW   = $clog2(MAXC) + 1
) (
  input  logic          up_clk,
  input  logic          up_rstn,
  input  logic          up_req_i,
  input  logic [PW-1:0] up_req_profile_i,
  input  logic          up_abort_i,
  input  logic          up_link_ready_i,
  input  logic          up_sync_status_i,
  output logic [PW-1:0] up_profile_sel_o,
  output logic          up_core_rst_o,
  output logic          up_ack_o,
  output logic          up_busy_o,
  output logic          up_done_o,
  output logic          up_error_o,
  output logic [2:0]    up_state_o
);
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ASSERT_RST = 3'd1,
    SWITCH     = 3'd2,
    SETTLE     = 3'd3,
    WAIT_SYNC  = 3'd4
  } state_t;
  localparam logic [PW-1:0] NP = PW'(NUM_PROFILES);
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] prof_q, prof_d, sel_q, sel_d;
  logic          rst_q, rst_d, ack_q, ack_d, done_q, done_d, err_q, err_d;
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prof_q  <= '0;
      sel_q   <= '0;
      rst_q   <= 1'b0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prof_q  <= prof_d;
      sel_q   <= sel_d;
      rst_q   <= rst_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prof_d  = prof_q;
    sel_d   = sel_q;
    rst_d   = rst_q;
    ack_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;
    // abort beats every in-state transition, including a coincident sync
    if (state_q != IDLE && up_abort_i) begin
      state_d = IDLE;
      rst_d   = 1'b0;
      err_d   = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (up_req_i) begin
          ack_d = 1'b1;
          if (up_req_profile_i < NP) begin
            state_d = ASSERT_RST;
            cnt_d   = CW'(RST_CYCLES - 1);
            prof_d  = up_req_profile_i;
            rst_d   = 1'b1;
            err_d   = 1'b0;
          end else err_d = 1'b1;
        end
        ASSERT_RST: begin
          state_d = cnt_q == '0 ? SWITCH : ASSERT_RST;
          cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
        end
        SWITCH: begin
          sel_d   = prof_q;
          cnt_d   = CW'(SETTLE_CYCLES - 1);
          state_d = SETTLE;
        end
        SETTLE: if (cnt_q == '0 && up_link_ready_i) begin
          state_d = WAIT_SYNC;
          rst_d   = 1'b0;
          cnt_d   = CW'(SYNC_TIMEOUT - 1);
        end else cnt_d = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
        WAIT_SYNC: if (up_sync_status_i) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else cnt_d = cnt_q - 1'b1;
        default: state_d = IDLE;
      endcase
    end
  end
  assign up_profile_sel_o = sel_q;
  assign up_core_rst_o    = rst_q;
  assign up_ack_o         = ack_q;
  assign up_busy_o        = state_q != IDLE;
  assign up_done_o        = done_q;
  assign up_error_o       = err_q;
  assign up_state_o       = state_q;
endmodule

// File: tb/tb_up_tpl_profile_seq.sv
// tb_up_tpl_profile_seq: directed self-checking bench for up_tpl_profile_seq
module tb_up_tpl_profile_seq;
  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       req = 1'b0, abort = 1'b0, link = 1'b1, sync = 1'b0;
  logic [2:0] prof = '0;
  logic [2:0] psel, state;
  logic       core_rst, ack, busy, done, err;
  int         n_chk = 0, n_fail = 0;
  up_tpl_profile_seq #(
    .NUM_PROFILES(4), .RST_CYCLES(16), .SETTLE_CYCLES(64), .SYNC_TIMEOUT(100)
  ) dut (
    .up_clk(clk), .up_rstn(rstn), .up_req_i(req), .up_req_profile_i(prof),
    .up_abort_i(abort), .up_link_ready_i(link), .up_sync_status_i(sync),
    .up_profile_sel_o(psel), .up_core_rst_o(core_rst), .up_ack_o(ack),
    .up_busy_o(busy), .up_done_o(done), .up_error_o(err), .up_state_o(state)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  initial begin
    tick(2);
    check("rst_state", {29'd0, state}, 0);
    check("rst_outs", {psel, core_rst, ack, busy, done, err}, 0);
    rstn = 1'b1;
    tick();
    // 1: nominal change to profile 2
    req = 1'b1; prof = 3'd2;
    tick();
    req = 1'b0;
    check("t1_ack", {ack, busy, core_rst, err}, 4'b1110);
    check("t1_state_ar", {29'd0, state}, 1);
    tick();
    check("t1_ack_pulse", {31'd0, ack}, 0);
    tick(14);
    check("t1_rst_15", {28'd0, state, core_rst}, {28'd0, 3'd1, 1'b1});
    tick();
    check("t1_switch", {28'd0, state, core_rst}, {28'd0, 3'd2, 1'b1});
    check("t1_psel_old", {29'd0, psel}, 0);
    tick();
    check("t1_settle", {29'd0, state}, 3);
    check("t1_psel_new", {29'd0, psel}, 2);
    tick(63);
    check("t1_settle_end", {28'd0, state, core_rst}, {28'd0, 3'd3, 1'b1});
    tick();
    check("t1_release", {28'd0, state, core_rst}, {28'd0, 3'd4, 1'b0});
    tick(9);
    check("t1_wait", {30'd0, busy, done}, 2'b10);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    check("t1_done", {27'd0, state, busy, done}, {27'd0, 3'd0, 1'b0, 1'b1});
    check("t1_err", {30'd0, err, ack}, 0);
    tick();
    check("t1_done_pulse", {31'd0, done}, 0);
    // 2: out-of-range profile rejected
    req = 1'b1; prof = 3'd5;
    tick();
    req = 1'b0;
    check("t2_ack_err", {ack, err, core_rst, busy}, 4'b1100);
    check("t2_psel", {26'd0, state, psel}, {26'd0, 3'd0, 3'd2});
    tick();
    check("t2_sticky", {30'd0, ack, err}, 2'b01);
    // 3: link stays low during settle; valid request clears error
    link = 1'b0;
    req = 1'b1; prof = 3'd1;
    tick();
    req = 1'b0;
    check("t3_err_clr", {30'd0, ack, err}, 2'b10);
    tick(17);
    check("t3_settle", {26'd0, state, psel}, {26'd0, 3'd3, 3'd1});
    tick(200);
    check("t3_held", {28'd0, state, core_rst}, {28'd0, 3'd3, 1'b1});
    link = 1'b1;
    tick();
    check("t3_release", {28'd0, state, core_rst}, {28'd0, 3'd4, 1'b0});
    // 4: sync timeout 100 cycles after release
    tick(99);
    check("t4_before_to", {29'd0, state, busy, err}, {27'd0, 3'd4, 1'b1, 1'b0});
    tick();
    check("t4_timeout", {27'd0, state, busy, err}, {27'd0, 3'd0, 1'b0, 1'b1});
    check("t4_psel", {29'd0, psel}, 1);
    check("t4_no_done", {31'd0, done}, 0);
    // 5: abort at 5th cycle of ASSERT_RST keeps old profile
    req = 1'b1; prof = 3'd3;
    tick();
    req = 1'b0;
    tick(4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_abort", {27'd0, state, core_rst, err}, {27'd0, 3'd0, 1'b0, 1'b1});
    check("t5_psel_old", {29'd0, psel}, 1);
    // abort coincident with sync in WAIT_SYNC: error, no done
    req = 1'b1; prof = 3'd2;
    tick();
    req = 1'b0;
    tick(81);
    check("t5_wait", {29'd0, state}, 4);
    abort = 1'b1; sync = 1'b1;
    tick();
    abort = 1'b0; sync = 1'b0;
    check("t5_abort_sync", {27'd0, state, done, err}, {27'd0, 3'd0, 1'b0, 1'b1});
    check("t5_psel_new", {29'd0, psel}, 2);
    // 6: abort+req in IDLE handles req; req while busy ignored; async reset mid-settle
    abort = 1'b1; req = 1'b1; prof = 3'd3;
    tick();
    abort = 1'b0; prof = 3'd1;
    check("t6_req_wins", {28'd0, state, ack}, {28'd0, 3'd1, 1'b1});
    tick();
    req = 1'b0;
    check("t6_busy_noack", {28'd0, state, ack}, {28'd0, 3'd1, 1'b0});
    tick(16);
    check("t6_settle", {26'd0, state, psel}, {26'd0, 3'd3, 3'd3});
    tick(10);
    rstn = 1'b0;
    #1;
    check("t6_async_rst", {26'd0, state, psel}, 0);
    check("t6_async_outs", {27'd0, core_rst, ack, busy, done, err}, 0);
    tick();
    rstn = 1'b1;
    tick(3);
    check("t6_idle_after", {28'd0, state, core_rst}, 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
